// File: rtl/mem_responder_pkg.sv
// Shared bus/core definitions for the memory responder: bus width, default
// geometry and the responder FSM state encoding.
package mem_responder_pkg;

   localparam int BUS_W        = 64;
   localparam int DEF_ADDR_W   = 10;
   localparam int DEF_DEPTH    = 1024;
   localparam int DEF_WAIT_CYC = 2;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      WAIT,
      READ,
      WRITE
   } state_e;

endpackage

// File: rtl/mem_array.sv
// Single-port DEPTH x 64 storage with synchronous read and write. The read
// register can be cleared so the responder can present zero for bad addresses.
module mem_array
   import mem_responder_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              we,
   input  logic              clr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [BUS_W-1:0]  wdata,
   output logic [BUS_W-1:0]  rdata
);

   logic [BUS_W-1:0] mem [DEPTH];

   // NOTE: the storage array has no reset so it maps onto block RAM and keeps
   // its contents across a responder reset; only the read register is reset.
   always_ff @(posedge clk) begin
      if (en && we) begin
         mem[addr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (clr) begin
         rdata <= '0;
      end else if (en && !we) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Bus-side memory responder: latches a word address, then serves one read
// (with programmable wait states) or one strobed write per nME frame.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int WAIT_CYC = DEF_WAIT_CYC
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [BUS_W-1:0] Sysbus_in,
   input  logic             nALE,
   input  logic             nME,
   input  logic             RnW,
   input  logic             nOE,
   input  logic             ENB,
   output logic [BUS_W-1:0] Data_out,
   output logic             Data_oe,
   output logic             Ready,
   output logic             Addr_err
);

   state_e            state;
   logic [3:0]        cnt;
   logic [ADDR_W-1:0] addr;
   logic              written;
   logic              load_read;
   logic              rd_en;
   logic              rd_clr;
   logic              wr_en;

   // NOTE: every always_comb output gets a default before the case so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      load_read = 1'b0;
      if (!Reset) begin
         unique case (state)
            ADDR:    load_read = !nME && RnW && (WAIT_CYC == 0);
            WAIT:    load_read = !nME && (cnt == 4'd1);
            default: load_read = 1'b0;
         endcase
      end
   end

   // The array is read on the same edge the FSM enters READ.
   assign rd_en  = load_read && !Addr_err;
   assign rd_clr = load_read && Addr_err;
   assign wr_en  = !Reset && (state == WRITE) && ENB && !written && !Addr_err;

   assign Data_oe = (state == READ) && !nOE;

   mem_array #(
      .ADDR_W(ADDR_W),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk  (Clock),
      .rst  (Reset),
      .en   (rd_en || wr_en),
      .we   (wr_en),
      .clr  (rd_clr),
      .addr (addr),
      .wdata(Sysbus_in),
      .rdata(Data_out)
   );

   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples pre-edge values, independent of statement order.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state    <= IDLE;
         cnt      <= '0;
         addr     <= '0;
         written  <= 1'b0;
         Ready    <= 1'b0;
         Addr_err <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (!nALE) begin
                  addr     <= Sysbus_in[ADDR_W-1:0];
                  Addr_err <= (Sysbus_in[BUS_W-1:ADDR_W] != '0) ||
                              ({1'b0, Sysbus_in[ADDR_W-1:0]} >= (ADDR_W+1)'(DEPTH));
                  state    <= ADDR;
               end
            end
            ADDR: begin
               if (!nME) begin
                  if (RnW) begin
                     cnt <= 4'(WAIT_CYC);
                     if (WAIT_CYC == 0) begin
                        state <= READ;
                        Ready <= 1'b1;
                     end else begin
                        state <= WAIT;
                     end
                  end else begin
                     written <= 1'b0;
                     state   <= WRITE;
                  end
               end
            end
            WAIT: begin
               if (nME) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 4'd1;
                  if (cnt == 4'd1) begin
                     state <= READ;
                     Ready <= 1'b1;
                  end
               end
            end
            READ: begin
               if (nME) begin
                  state <= IDLE;
                  Ready <= 1'b0;
               end
            end
            WRITE: begin
               if (nME) begin
                  state <= IDLE;
                  Ready <= 1'b0;
               end else if (ENB && !written) begin
                  written <= 1'b1;
                  Ready   <= 1'b1;
               end else begin
                  Ready <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: a WAIT_CYC=2 and a WAIT_CYC=0 responder, a table of
// accesses with a read-data scoreboard, plus hand-written corner sequences.
module tb_mem_responder;

   typedef struct {
      logic [63:0] addr;
      bit          wr;
      logic [63:0] data;
      logic        err;
   } vec_t;

   localparam int NV = 13;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] bus;
   logic [1:0]  nale;
   logic [1:0]  nme;
   logic        rnw;
   logic        noe;
   logic        enb;
   logic [63:0] dout [2];
   logic        doe  [2];
   logic        rdy  [2];
   logic        aerr [2];

   int          n_checks = 0;
   int          n_errors = 0;
   logic [63:0] model [int];
   logic [63:0] exp_q [$];
   logic [63:0] last_rd = '0;
   vec_t        vecs [NV];

   always #5 clk = ~clk;

   mem_responder #(.WAIT_CYC(2)) dut (
      .Clock(clk), .Reset(rst), .Sysbus_in(bus), .nALE(nale[0]), .nME(nme[0]),
      .RnW(rnw), .nOE(noe), .ENB(enb), .Data_out(dout[0]), .Data_oe(doe[0]),
      .Ready(rdy[0]), .Addr_err(aerr[0])
   );

   mem_responder #(.WAIT_CYC(0)) dut0 (
      .Clock(clk), .Reset(rst), .Sysbus_in(bus), .nALE(nale[1]), .nME(nme[1]),
      .RnW(rnw), .nOE(noe), .ENB(enb), .Data_out(dout[1]), .Data_oe(doe[1]),
      .Ready(rdy[1]), .Addr_err(aerr[1])
   );

   function automatic int key(input int s, input logic [63:0] a);
      return s * 1024 + int'(a[9:0]);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic latch(input int s, input logic [63:0] a, input logic exp_err);
      bus     = a;
      nale[s] = 1'b0;
      tick();
      nale[s] = 1'b1;
      check("addr_err", aerr[s], exp_err);
   endtask

   task automatic do_write(input int s, input logic [63:0] a, input logic [63:0] d,
                           input logic err);
      latch(s, a, err);
      rnw    = 1'b0;
      nme[s] = 1'b0;
      tick();
      bus = d;
      enb = 1'b1;
      tick();
      check("write_ready", rdy[s], 1'b1);
      enb    = 1'b0;
      nme[s] = 1'b1;
      tick();
      check("write_done", rdy[s], 1'b0);
      if (!err) model[key(s, a)] = d;
   endtask

   task automatic do_read(input int s, input logic [63:0] a, input logic err,
                          input int waitc);
      int          edges;
      logic [63:0] exp;
      latch(s, a, err);
      exp_q.push_back(err ? 64'h0 : model[key(s, a)]);
      rnw    = 1'b1;
      nme[s] = 1'b0;
      tick();
      edges = 0;
      while (!rdy[s] && edges < 40) begin
         tick();
         edges++;
      end
      check("read_latency", edges, waitc);
      check("read_oe", doe[s], 1'b1);
      if (exp_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL sb_empty: got no queued entry expected one");
      end else begin
         exp = exp_q.pop_front();
         check("read_data", dout[s], exp);
         last_rd = exp;
      end
      nme[s] = 1'b1;
      tick();
      check("read_done", {rdy[s], doe[s]}, 2'b00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic any_rdy;

      vecs[0]  = '{64'd5,                  1'b1, 64'hDEAD_BEEF_0123_4567, 1'b0};
      vecs[1]  = '{64'd5,                  1'b0, 64'h0,                   1'b0};
      vecs[2]  = '{64'd0,                  1'b1, 64'h0A0A_0B0B_0C0C_0D0D, 1'b0};
      vecs[3]  = '{64'h400,                1'b1, 64'hFFFF,                1'b1};
      vecs[4]  = '{64'h400,                1'b0, 64'h0,                   1'b1};
      vecs[5]  = '{64'd0,                  1'b0, 64'h0,                   1'b0};
      vecs[6]  = '{64'd3,                  1'b1, 64'd1,                   1'b0};
      vecs[7]  = '{64'd3,                  1'b1, 64'd2,                   1'b0};
      vecs[8]  = '{64'd3,                  1'b0, 64'h0,                   1'b0};
      vecs[9]  = '{64'd1023,               1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0};
      vecs[10] = '{64'd1023,               1'b0, 64'h0,                   1'b0};
      vecs[11] = '{64'h0000_0001_0000_0005, 1'b0, 64'h0,                  1'b1};
      vecs[12] = '{64'd9,                  1'b1, 64'h9999_0000_9999_0000, 1'b0};

      // NOTE: stimulus is driven with blocking assignments just after the
      // edge so the DUT samples settled values on the next rising edge.
      rst  = 1'b1;
      bus  = '0;
      nale = 2'b11;
      nme  = 2'b11;
      rnw  = 1'b1;
      noe  = 1'b0;
      enb  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      for (int s = 0; s < 2; s++) begin
         check("rst_dout", dout[s], 64'h0);
         check("rst_oe", doe[s], 1'b0);
         check("rst_ready", rdy[s], 1'b0);
         check("rst_addr_err", aerr[s], 1'b0);
      end

      for (int i = 0; i < NV; i++) begin
         if (vecs[i].wr) do_write(0, vecs[i].addr, vecs[i].data, vecs[i].err);
         else            do_read(0, vecs[i].addr, vecs[i].err, 2);
      end

      // A second ENB pulse within one write frame must be dropped.
      latch(0, 64'd4, 1'b0);
      rnw    = 1'b0;
      nme[0] = 1'b0;
      tick();
      bus = 64'hAAAA;
      enb = 1'b1;
      tick();
      check("enb1_ready", rdy[0], 1'b1);
      enb = 1'b0;
      tick();
      check("enb1_ready_pulse", rdy[0], 1'b0);
      bus = 64'hBBBB;
      enb = 1'b1;
      tick();
      check("enb2_ready", rdy[0], 1'b0);
      enb    = 1'b0;
      nme[0] = 1'b1;
      tick();
      model[key(0, 64'd4)] = 64'hAAAA;
      do_read(0, 64'd4, 1'b0, 2);

      // Abort during WAIT: no Ready, Data_out keeps the previous read.
      latch(0, 64'd7, 1'b0);
      rnw    = 1'b1;
      nme[0] = 1'b0;
      tick();
      nme[0]  = 1'b1;
      any_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         any_rdy |= rdy[0];
      end
      check("abort_ready", any_rdy, 1'b0);
      check("abort_dout", dout[0], last_rd);
      do_write(0, 64'd7, 64'h7777_0000_0000_7777, 1'b0);
      do_read(0, 64'd7, 1'b0, 2);

      // Stray nALE with an out-of-range value during a read of address 3.
      latch(0, 64'd3, 1'b0);
      rnw     = 1'b1;
      nme[0]  = 1'b0;
      bus     = 64'h400;
      nale[0] = 1'b0;
      tick();
      tick();
      tick();
      check("stray_ready", rdy[0], 1'b1);
      check("stray_addr_err", aerr[0], 1'b0);
      check("stray_dout", dout[0], 64'd2);
      tick();
      check("stray_dout_hold", dout[0], 64'd2);
      nale[0] = 1'b1;
      nme[0]  = 1'b1;
      tick();

      // Reset while in WRITE before any ENB strobe.
      latch(0, 64'd9, 1'b0);
      rnw    = 1'b0;
      nme[0] = 1'b0;
      tick();
      bus = 64'h0BAD_0BAD_0BAD_0BAD;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_dout", dout[0], 64'h0);
      check("midrst_oe", doe[0], 1'b0);
      check("midrst_ready", rdy[0], 1'b0);
      check("midrst_addr_err", aerr[0], 1'b0);
      nme[0] = 1'b1;
      tick();
      do_read(0, 64'd9, 1'b0, 2);

      // Zero-wait responder: contents survive reset, Data_oe tracks nOE.
      do_write(1, 64'd0, 64'h5A5A_0000_0000_5A5A, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      latch(1, 64'd0, 1'b0);
      rnw    = 1'b1;
      nme[1] = 1'b0;
      tick();
      check("zw_ready", rdy[1], 1'b1);
      check("zw_dout", dout[1], 64'h5A5A_0000_0000_5A5A);
      noe = 1'b1;
      #1;
      check("zw_oe_off", doe[1], 1'b0);
      noe = 1'b0;
      #1;
      check("zw_oe_on", doe[1], 1'b1);
      tick();
      check("zw_dout_hold", dout[1], 64'h5A5A_0000_0000_5A5A);
      check("zw_ready_hold", rdy[1], 1'b1);
      nme[1] = 1'b1;
      tick();
      check("zw_done", rdy[1], 1'b0);
      do_read(1, 64'd0, 1'b0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 10, word-address width; DEPTH, default 1024, number of 64-bit words; WAIT_CYC, default 2, read wait states (0..15).
REQ-002 Reset: one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous active-high reset.
- Sysbus_in  in  64  bus value: address during nALE low, write data during write.
- nALE  in  1  active-low address latch enable.
- nME  in  1  active-low memory enable; frames one access.
- RnW  in  1  1 = read, 0 = write; sampled with nME.
- nOE  in  1  active-low output enable for read data.
- ENB  in  1  write-data strobe, active high.
- Data_out  out  64  read data, routed to the core's Data_in.
- Data_oe  out  1  read data valid on Data_out.
- Ready  out  1  access complete.
- Addr_err  out  1  latched address is out of range.

Function
REQ-004 The FSM SHALL have states IDLE, ADDR, WAIT, READ and WRITE.
REQ-005 In IDLE, nALE sampled low SHALL latch Sysbus_in[ADDR_W-1:0] as the word address and go to ADDR.
REQ-006 On that same edge, Addr_err SHALL register 1 if Sysbus_in[63:ADDR_W] is nonzero or the address is >= DEPTH, else 0.
REQ-007 In ADDR, nME sampled low with RnW=1 SHALL load the counter with WAIT_CYC, going to READ if WAIT_CYC=0 and to WAIT otherwise.
REQ-008 In ADDR, nME sampled low with RnW=0 SHALL go to WRITE.
REQ-009 In ADDR, nME high SHALL hold the state.
REQ-010 In WAIT, the counter SHALL decrement every cycle; at counter=1 the next state SHALL be READ, so READ is entered exactly WAIT_CYC edges after the nME-low sample.
REQ-011 On entry to READ, Data_out SHALL register mem[addr], or 64'h0 if Addr_err=1, and Ready SHALL register 1.
REQ-012 Data_oe SHALL be combinational: (state==READ) AND NOT nOE.
REQ-013 Data_out SHALL hold stable for the whole of READ.
REQ-014 In WRITE, ENB sampled high SHALL write Sysbus_in into mem[addr] unless Addr_err=1, and SHALL set Ready for one cycle.
REQ-015 A further ENB pulse in the same WRITE access SHALL be ignored.
REQ-016 In READ or WRITE, nME sampled high SHALL return the FSM to IDLE and clear Ready on the same edge.
REQ-017 In WAIT, nME sampled high SHALL abort to IDLE: no Ready, Data_out unchanged.
REQ-018 nALE low outside IDLE SHALL be ignored; the latched address is not updated.
REQ-019 Back-to-back accesses SHALL be accepted: nALE low is honoured on the first cycle back in IDLE.
REQ-020 The memory SHALL be a single-port array with synchronous read and write, at most one access per cycle.

Reset
REQ-021 Reset SHALL force state=IDLE, counter=0, Data_out=0, Ready=0 and Addr_err=0, so Data_oe=0.
REQ-022 Reset asserted mid-access SHALL abandon that access; a WRITE not yet strobed SHALL leave memory unchanged.
REQ-023 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-024 The state enum, default ADDR_W/DEPTH/WAIT_CYC and the bus-width constant (64) SHALL live in the shared package with the core's opcode/bus definitions.
REQ-025 The storage SHALL be one sub-module, mem_array (DEPTH x 64, synchronous read and write); the FSM and counter SHALL stay in mem_responder.

Verification
REQ-026 Read with WAIT_CYC=2: write 64'hDEAD_BEEF_0123_4567 to address 5, then read address 5 with nOE low -> Ready and Data_oe rise exactly 2 edges after the nME-low sample, Data_out=64'hDEAD_BEEF_0123_4567.
REQ-027 Zero-wait read: WAIT_CYC=0, read address 0 after reset -> Ready the cycle after the nME-low sample; Data_oe follows nOE toggling during READ.
REQ-028 Out-of-range: nALE with Sysbus_in=64'h400 (ADDR_W=10) -> Addr_err=1; read returns 0; a write of 64'hFFFF is dropped and address 0 still reads its old value.
REQ-029 Abort: nME deasserted during WAIT -> IDLE, Ready never asserts; the next access to address 7 completes normally.
REQ-030 Reset mid-write: Reset asserted in WRITE before ENB -> all outputs 0 next cycle; a read of the target address returns its prior contents.
REQ-031 Back-to-back: write address 3 = 1, then write 3 = 2, then read 3 -> 2; a stray nALE during the read leaves the address unchanged.
